// File: rtl/z80fi_bus_recorder.sv
// Passive z80fi bus recorder: watches T-state bus strobes and assembles one
// per-instruction record (bytes, M-cycle types, T-counts, first mem read/write).
module z80fi_bus_recorder #(
  parameter int MAX_MCYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        insn_start,
  input  logic        mcycle_start,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [2:0]  z80fi_insn_len,
  output logic [15:0] z80fi_reg_ip_in,
  output logic [2:0]  z80fi_mcycle_type1,
  output logic [2:0]  z80fi_mcycle_type2,
  output logic [2:0]  z80fi_mcycle_type3,
  output logic [2:0]  z80fi_mcycle_type4,
  output logic [3:0]  z80fi_tcycles1,
  output logic [3:0]  z80fi_tcycles2,
  output logic [3:0]  z80fi_tcycles3,
  output logic [3:0]  z80fi_tcycles4,
  output logic [15:0] z80fi_bus_raddr,
  output logic [7:0]  z80fi_bus_rdata,
  output logic [15:0] z80fi_bus_waddr,
  output logic [7:0]  z80fi_bus_wdata,
  output logic        rec_overflow,
  output logic        dbg_state
);

  localparam logic [2:0] CYCLE_NONE     = 3'd0;
  localparam logic [2:0] CYCLE_M1       = 3'd1;
  localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;
  localparam logic [2:0] CYCLE_RDWR_IO  = 3'd3;
  localparam logic [2:0] CYCLE_INTERNAL = 3'd4;

  localparam int IW = $clog2(MAX_MCYCLES + 2);
  localparam logic [IW-1:0] MAX_IDX = IW'(MAX_MCYCLES);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  typedef struct packed {
    logic [31:0]     insn;
    logic [2:0]      len;
    logic [15:0]     ip;
    logic [3:0][2:0] types;
    logic [3:0][3:0] tcs;
    logic [15:0]     raddr;
    logic [7:0]      rdata;
    logic [15:0]     waddr;
    logic [7:0]      wdata;
    logic            ovf;
  } rec_t;

  // Strobe history of the M-cycle in progress; bytes keep the last strobed clock.
  typedef struct packed {
    logic        m1;
    logic        mreq;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
  } cyc_t;

  state_t         state_q, state_d;
  rec_t           rec_q, closed, open_rec, out_q;
  cyc_t           cyc_q, cyc_d;
  logic           valid_q, emit;
  logic           rdone_q, wdone_q, rdone_c, wdone_c;
  logic [IW-1:0]  idx_q, idx_close;
  logic [3:0]     tcnt_q;
  logic [2:0]     cyc_type;
  logic [15:0]    exp_addr;
  logic           is_mem, do_append;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    if (insn_start) begin
      state_d = COLLECT;
      emit    = (state_q == COLLECT);
    end
  end

  always_comb begin
    cyc_d = (insn_start || mcycle_start) ? '0 : cyc_q;
    cyc_d.m1   = cyc_d.m1   | (!m1_n && !mreq_n);
    cyc_d.mreq = cyc_d.mreq | !mreq_n;
    cyc_d.iorq = cyc_d.iorq | !iorq_n;
    cyc_d.rd   = cyc_d.rd   | !rd_n;
    cyc_d.wr   = cyc_d.wr   | !wr_n;
    if (!rd_n) begin
      cyc_d.rd_addr = addr;
      cyc_d.rd_data = data;
    end
    if (!wr_n) begin
      cyc_d.wr_addr = addr;
      cyc_d.wr_data = data;
    end
    open_rec    = '0;
    open_rec.ip = addr;
  end

  // Record as it looks once the current M-cycle is folded in.
  always_comb begin
    if (cyc_q.m1)        cyc_type = CYCLE_M1;
    else if (cyc_q.mreq) cyc_type = CYCLE_RDWR_MEM;
    else if (cyc_q.iorq) cyc_type = CYCLE_RDWR_IO;
    else                 cyc_type = CYCLE_INTERNAL;

    closed    = rec_q;
    rdone_c   = rdone_q;
    wdone_c   = wdone_q;
    idx_close = idx_q;
    exp_addr  = rec_q.ip + 16'(rec_q.len);
    is_mem    = (cyc_type == CYCLE_RDWR_MEM);
    do_append = (cyc_type == CYCLE_M1) ||
                (is_mem && cyc_q.rd && (cyc_q.rd_addr == exp_addr));

    for (int k = 0; k < 4; k++) begin
      if (k < MAX_MCYCLES && idx_q == IW'(k + 1)) begin
        closed.types[k] = cyc_type;
        closed.tcs[k]   = tcnt_q;
      end
    end
    if (idx_q > MAX_IDX) closed.ovf = 1'b1;
    else                 idx_close = idx_q + 1'b1;

    if (do_append) begin
      if (rec_q.len == 3'd4) begin
        closed.ovf = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (rec_q.len == 3'(k)) closed.insn[8*k +: 8] = cyc_q.rd_data;
        end
        closed.len = rec_q.len + 3'd1;
      end
    end

    if (is_mem && cyc_q.rd && !do_append && !rdone_q) begin
      closed.raddr = cyc_q.rd_addr;
      closed.rdata = cyc_q.rd_data;
      rdone_c      = 1'b1;
    end
    if (is_mem && cyc_q.wr && !wdone_q) begin
      closed.waddr = cyc_q.wr_addr;
      closed.wdata = cyc_q.wr_data;
      wdone_c      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rec_q   <= '0;
      out_q   <= '0;
      cyc_q   <= '0;
      valid_q <= 1'b0;
      rdone_q <= 1'b0;
      wdone_q <= 1'b0;
      idx_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= emit;
      cyc_q   <= cyc_d;
      if (emit) out_q <= closed;
      if (insn_start) begin
        rec_q   <= open_rec;
        rdone_q <= 1'b0;
        wdone_q <= 1'b0;
        idx_q   <= IW'(1);
        tcnt_q  <= 4'd1;
      end else if (state_q == COLLECT) begin
        if (mcycle_start) begin
          rec_q   <= closed;
          rdone_q <= rdone_c;
          wdone_q <= wdone_c;
          idx_q   <= idx_close;
          tcnt_q  <= 4'd1;
        end else if (tcnt_q != 4'hF) begin
          tcnt_q <= tcnt_q + 4'd1;
        end
      end
    end
  end

  assign z80fi_valid        = valid_q;
  assign z80fi_insn         = out_q.insn;
  assign z80fi_insn_len     = out_q.len;
  assign z80fi_reg_ip_in    = out_q.ip;
  assign z80fi_mcycle_type1 = out_q.types[0];
  assign z80fi_mcycle_type2 = out_q.types[1];
  assign z80fi_mcycle_type3 = out_q.types[2];
  assign z80fi_mcycle_type4 = out_q.types[3];
  assign z80fi_tcycles1     = out_q.tcs[0];
  assign z80fi_tcycles2     = out_q.tcs[1];
  assign z80fi_tcycles3     = out_q.tcs[2];
  assign z80fi_tcycles4     = out_q.tcs[3];
  assign z80fi_bus_raddr    = out_q.raddr;
  assign z80fi_bus_rdata    = out_q.rdata;
  assign z80fi_bus_waddr    = out_q.waddr;
  assign z80fi_bus_wdata    = out_q.wdata;
  assign rec_overflow       = out_q.ovf;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_z80fi_bus_recorder.sv
// Directed bench for z80fi_bus_recorder: drives T-state bus sequences for
// small instruction streams and checks each emitted record against hand values.
module tb_z80fi_bus_recorder;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_M1   = 3'd1;
  localparam logic [2:0] C_MEM  = 3'd2;
  localparam logic [2:0] C_IO   = 3'd3;
  localparam logic [2:0] C_INT  = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        insn_start = 1'b0, mcycle_start = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data = 8'h0;
  logic        z80fi_valid, rec_overflow, dbg_state;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in, z80fi_bus_raddr, z80fi_bus_waddr;
  logic [2:0]  t1, t2, t3, t4;
  logic [3:0]  c1, c2, c3, c4;
  logic [7:0]  z80fi_bus_rdata, z80fi_bus_wdata;

  int checks = 0;
  int errors = 0;

  z80fi_bus_recorder #(.MAX_MCYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .insn_start(insn_start), .mcycle_start(mcycle_start),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data(data),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg_ip_in(z80fi_reg_ip_in),
    .z80fi_mcycle_type1(t1), .z80fi_mcycle_type2(t2),
    .z80fi_mcycle_type3(t3), .z80fi_mcycle_type4(t4),
    .z80fi_tcycles1(c1), .z80fi_tcycles2(c2), .z80fi_tcycles3(c3), .z80fi_tcycles4(c4),
    .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_rdata(z80fi_bus_rdata),
    .z80fi_bus_waddr(z80fi_bus_waddr), .z80fi_bus_wdata(z80fi_bus_wdata),
    .rec_overflow(rec_overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One T-state: drive after the falling edge, return just after the sampling edge.
  task automatic tstate(input logic ins, input logic mcs, input logic m1, input logic mreq,
                        input logic iorq, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    insn_start = ins; mcycle_start = mcs;
    m1_n = m1; mreq_n = mreq; iorq_n = iorq; rd_n = rd; wr_n = wr;
    addr = a; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic insn_open(input logic [15:0] a, input logic [7:0] b);
    tstate(1, 1, 0, 0, 1, 0, 1, a, b);
  endtask

  task automatic m1_tail(input logic [15:0] a, input logic [7:0] b, input int n);
    tstate(0, 0, 0, 0, 1, 0, 1, a, b);
    for (int i = 2; i < n; i++) tstate(0, 0, 1, 1, 1, 1, 1, a, 8'h00);
  endtask

  task automatic bus_cyc(input logic m1, input logic mreq, input logic iorq, input logic rd,
                         input logic wr, input logic [15:0] a, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) tstate(0, (i == 0), m1, mreq, iorq, rd, wr, a, d);
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] insn, input logic [2:0] len,
                         input logic [15:0] ip, input logic [11:0] types, input logic [15:0] tcs,
                         input logic [15:0] raddr, input logic [7:0] rdata,
                         input logic [15:0] waddr, input logic [7:0] wdata, input logic ovf);
    chk({tag, ".valid"}, z80fi_valid, 1'b1);
    chk({tag, ".insn"}, z80fi_insn, insn);
    chk({tag, ".len"}, z80fi_insn_len, len);
    chk({tag, ".ip"}, z80fi_reg_ip_in, ip);
    chk({tag, ".types"}, {t1, t2, t3, t4}, types);
    chk({tag, ".tcycles"}, {c1, c2, c3, c4}, tcs);
    chk({tag, ".raddr"}, z80fi_bus_raddr, raddr);
    chk({tag, ".rdata"}, z80fi_bus_rdata, rdata);
    chk({tag, ".waddr"}, z80fi_bus_waddr, waddr);
    chk({tag, ".wdata"}, z80fi_bus_wdata, wdata);
    chk({tag, ".ovf"}, rec_overflow, ovf);
  endtask

  initial begin
    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", z80fi_valid, 1'b0);
    chk("rst.insn", z80fi_insn, 32'h0);
    chk("rst.types", {t1, t2, t3, t4}, {C_NONE, C_NONE, C_NONE, C_NONE});
    chk("rst.state", dbg_state, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tstate(0, 1, 1, 1, 1, 1, 1, 16'h0, 8'h0);
    chk("idle.state", dbg_state, 1'b0);

    // NOP at 0x0000: first insn_start after reset never emits
    insn_open(16'h0000, 8'h00);
    chk("first.valid", z80fi_valid, 1'b0);
    chk("first.state", dbg_state, 1'b1);
    m1_tail(16'h0000, 8'h00, 4);

    // LD A,0x55 at 0x0001
    insn_open(16'h0001, 8'h3E);
    chk_rec("nop", 32'h0, 3'd1, 16'h0000, {C_M1, C_NONE, C_NONE, C_NONE},
            16'h4000, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0);
    m1_tail(16'h0001, 8'h3E, 4);
    chk("pulse.valid", z80fi_valid, 1'b0);
    bus_cyc(1, 0, 1, 0, 1, 16'h0002, 8'h55, 3);

    // BIT 0,(HL) at 0x0100, HL=0x2000
    insn_open(16'h0100, 8'hCB);
    chk_rec("ldan", 32'h0000553E, 3'd2, 16'h0001, {C_M1, C_MEM, C_NONE, C_NONE},
            16'h4300, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0);
    m1_tail(16'h0100, 8'hCB, 4);
    bus_cyc(0, 0, 1, 0, 1, 16'h0101, 8'h46, 1);
    m1_tail(16'h0101, 8'h46, 4);
    bus_cyc(1, 0, 1, 0, 1, 16'h2000, 8'hFE, 4);

    // LD (HL),A at 0x0102, HL=0x3000, A=0x12
    insn_open(16'h0102, 8'h77);
    chk_rec("bit", 32'h000046CB, 3'd2, 16'h0100, {C_M1, C_M1, C_MEM, C_NONE},
            16'h4440, 16'h2000, 8'hFE, 16'h0, 8'h0, 1'b0);
    m1_tail(16'h0102, 8'h77, 4);
    bus_cyc(1, 0, 1, 1, 0, 16'h3000, 8'h12, 3);

    // Five M-cycles of 3T: M1, IO read, three internal
    insn_open(16'h0103, 8'hED);
    chk_rec("ldhl", 32'h00000077, 3'd1, 16'h0102, {C_M1, C_MEM, C_NONE, C_NONE},
            16'h4300, 16'h0, 8'h0, 16'h3000, 8'h12, 1'b0);
    m1_tail(16'h0103, 8'hED, 3);
    bus_cyc(1, 1, 0, 0, 1, 16'h0010, 8'hAA, 3);
    for (int i = 0; i < 3; i++) bus_cyc(1, 1, 1, 1, 1, 16'h0, 8'h0, 3);

    // Four-byte instruction DD CB 05 46 at 0x0104
    insn_open(16'h0104, 8'hDD);
    chk_rec("ovf", 32'h000000ED, 3'd1, 16'h0103, {C_M1, C_IO, C_INT, C_INT},
            16'h3333, 16'h0, 8'h0, 16'h0, 8'h0, 1'b1);
    m1_tail(16'h0104, 8'hDD, 4);
    bus_cyc(0, 0, 1, 0, 1, 16'h0105, 8'hCB, 1);
    m1_tail(16'h0105, 8'hCB, 4);
    bus_cyc(1, 0, 1, 0, 1, 16'h0106, 8'h05, 3);
    bus_cyc(1, 0, 1, 0, 1, 16'h0107, 8'h46, 3);

    // NOP plus 20-T internal cycle at 0x0108
    insn_open(16'h0108, 8'h00);
    chk_rec("len4", 32'h4605CBDD, 3'd4, 16'h0104, {C_M1, C_M1, C_MEM, C_MEM},
            16'h4433, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0);
    m1_tail(16'h0108, 8'h00, 4);
    bus_cyc(1, 1, 1, 1, 1, 16'h0, 8'h0, 20);

    // Back-to-back insn_start at 0x0109 then 0x010A
    insn_open(16'h0109, 8'hAF);
    chk_rec("sat", 32'h0, 3'd1, 16'h0108, {C_M1, C_INT, C_NONE, C_NONE},
            16'h4F00, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0);
    insn_open(16'h010A, 8'hC9);
    chk_rec("b2b", 32'h000000AF, 3'd1, 16'h0109, {C_M1, C_NONE, C_NONE, C_NONE},
            16'h1000, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0);

    // Reset mid-instruction drops the open record
    tstate(0, 0, 0, 0, 1, 0, 1, 16'h010A, 8'hC9);
    @(negedge clk);
    reset_n = 1'b0;
    insn_start = 1'b0; mcycle_start = 1'b0;
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.valid", z80fi_valid, 1'b0);
    chk("mrst.insn", z80fi_insn, 32'h0);
    chk("mrst.ip", z80fi_reg_ip_in, 16'h0);
    chk("mrst.state", dbg_state, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    insn_open(16'h0200, 8'h3C);
    chk("post1.valid", z80fi_valid, 1'b0);
    m1_tail(16'h0200, 8'h3C, 4);
    insn_open(16'h0201, 8'h00);
    chk_rec("post", 32'h0000003C, 3'd1, 16'h0200, {C_M1, C_NONE, C_NONE, C_NONE},
            16'h4000, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0);
    tstate(0, 0, 1, 1, 1, 1, 1, 16'h0201, 8'h00);
    chk("post.pulse", z80fi_valid, 1'b0);
    chk("post.hold", z80fi_insn, 32'h0000003C);

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80fi_bus_recorder.md
# z80fi_bus_recorder

Passive bus monitor that builds the z80fi per-instruction record from the CPU's T-state-level bus activity. It captures the instruction bytes, instruction length, M-cycle types, T-cycle counts, starting IP and first memory read/write of each instruction. The instruction spec checkers compare their `spec_*` outputs against this record. It sits beside the core in the formal and simulation harness and never drives the CPU bus.

## Interface
Parameters:
- MAX_MCYCLES, 4, number of M-cycle type slots recorded; cycles beyond this set `rec_overflow`.

Ports:
- `clk`  in  1  one rising edge per T-state.
- `reset_n`  in  1  asynchronous, active-low reset.
- `insn_start`  in  1  core strobe, high during T1 of the first M1 cycle of every instruction.
- `mcycle_start`  in  1  core strobe, high during T1 of every M-cycle; it is also high whenever `insn_start` is high.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`  in  1 each  CPU bus strobes, active-low.
- `addr`  in  16  CPU address bus.
- `data`  in  8  data bus value in the current T-state: read data when `rd_n`=0, write data when `wr_n`=0.
- `z80fi_valid`  out  1  one-clock pulse; the record outputs below are valid while it is high.
- `z80fi_insn`  out  32  instruction bytes; byte k occupies bits [8k+7:8k].
- `z80fi_insn_len`  out  3  number of instruction bytes, 0..4.
- `z80fi_reg_ip_in`  out  16  `addr` sampled at `insn_start`.
- `z80fi_mcycle_type1`..`z80fi_mcycle_type4`  out  3 each  `CYCLE_*` codes from z80.vh.
- `z80fi_tcycles1`..`z80fi_tcycles4`  out  4 each  T-states per M-cycle, saturating at 15.
- `z80fi_bus_raddr` / `z80fi_bus_rdata`  out  16/8  first non-M1 memory read.
- `z80fi_bus_waddr` / `z80fi_bus_wdata`  out  16/8  first memory write.
- `rec_overflow`  out  1  asserted with `z80fi_valid` when the instruction had more than MAX_MCYCLES M-cycles or more than 4 instruction bytes.

## Operation
- States:
  - IDLE: after reset; nothing is recorded.
  - COLLECT: a record is open.
- IDLE -> COLLECT on `insn_start`. COLLECT -> COLLECT on each later `insn_start`, which closes the current record and opens a new one. No other transitions.
- Opening a record:
  - clear all fields and set `mcycle_idx`=1, `tcnt`=1.
  - latch `ip` = `addr`.
  - set `insn_len` = 0.
- Each clock in COLLECT without `mcycle_start`: `tcnt` += 1, saturating at 15.
- Classifying the current M-cycle from strobes sampled during it, in priority order:
  1. `m1_n`=0 and `mreq_n`=0 gives `CYCLE_M1`.
  2. `mreq_n`=0 gives `CYCLE_RDWR_MEM`.
  3. `iorq_n`=0 gives `CYCLE_RDWR_IO`.
  4. no strobe gives `CYCLE_INTERNAL`.
- Byte capture: the read byte of an M-cycle is `data` on the last clock of that cycle with `rd_n`=0.
- Closing an M-cycle (on `mcycle_start` or `insn_start`):
  - write its type into slot `mcycle_idx` and `tcnt` into the matching `tcycles` slot.
  - append the read byte to `insn` when either: the cycle is an M1 cycle; or it is a memory read with address == `ip` + `insn_len` (16-bit wrap).
  - if the cycle is the first memory read that is not an M1 and was not appended, capture `raddr`/`rdata`.
  - if it is the first memory write, capture `waddr`/`wdata` (data on the last clock with `wr_n`=0).
  - then `mcycle_idx` += 1, `tcnt` = 1.
- Bounds and overflow:
  - slots with `mcycle_idx` > MAX_MCYCLES are discarded and set the overflow flag.
  - a fifth instruction byte is discarded and sets the overflow flag.
  - unused slots read as `CYCLE_NONE` / 0.
- Emission: when `insn_start` arrives in COLLECT, the closed record is registered to the outputs and `z80fi_valid` is pulsed. The final instruction before reset is never emitted.

## Timing
- Every output resets to 0, with all types at `CYCLE_NONE`. The state resets to IDLE.
- Latency: `z80fi_valid` is high exactly in the clock after `insn_start` is sampled. The outputs hold their values until the next emission.
- Back-to-back `insn_start` on consecutive clocks yields a record with one M-cycle of 1 T-state. This is legal.
- `reset_n` deasserted mid-record drops the record with no emission. The first `insn_start` after reset does not emit.
- Strobes are sampled only on `clk` rising edges; the block applies no glitch filtering.

## Test plan
- BIT 0,(HL) sequence, with ip=0x0100, HL=0x2000 and mem[0x2000]=0xFE: an M1 fetching CB (4T), an M1 fetching 46 (4T), a memory read (4T), then `insn_start`. Required record: insn[15:0]=0x46CB, len=2, types M1/M1/RDWR_MEM/NONE, tcycles 4/4/4/0, raddr=0x2000, rdata=0xFE, ip_in=0x0100.
- NOP, LD A,n (n=0x55) at ip 0x0000: first record has len=1, insn[7:0]=0x00, tcycles1=4. Second record has len=2, insn[15:0]=0x553E, types M1/RDWR_MEM, and raddr/rdata both 0.
- LD (HL),A with HL=0x3000, A=0x12: waddr=0x3000, wdata=0x12, types M1/RDWR_MEM, tcycles 4/3.
- Five M-cycles each 3T, or a 5-byte fetch: `rec_overflow`=1 with `z80fi_valid`, and slots 1–4 are still filled.
- A 20-T-state internal cycle: tcycles saturates at 15 and the type is `CYCLE_INTERNAL`.
- Reset pulse mid-instruction, then two `insn_start` strobes: no emission for the first; a single valid pulse after the second, containing only post-reset data.
